// File: rtl/demux_countdown.sv
// Capture-and-hold demultiplexer: latches one word, counts it down on enabled
// cycles, then releases it with a one-cycle strobe on channel A or channel B.
module demux_countdown #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             sel,
  input  logic             enable,
  input  logic             flush,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    COUNT = 2'b10,
    ROUTE = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             release_d;
  logic [WIDTH-1:0] out_a_q;
  logic [WIDTH-1:0] out_b_q;
  logic             valid_a_q;
  logic             valid_b_q;
  logic             ovf_q;

  // The counter parks at zero instead of wrapping.
  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] val);
    return (val == '0) ? '0 : val - WIDTH'(1);
  endfunction

  // flush outranks enable, so a flush edge never also decrements.
  always_comb begin
    release_d = 1'b0;
    cnt_d     = cnt_q;
    if (state_q == COUNT) begin
      if (flush || (enable && cnt_q == '0)) begin
        release_d = 1'b1;
      end else if (enable) begin
        cnt_d = dec_sat(cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      if (valid_in && state_q != IDLE) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            data_q  <= data_in;
            sel_q   <= sel;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= data_q;
          state_q <= COUNT;
        end
        COUNT: begin
          cnt_q <= cnt_d;
          if (release_d) begin
            state_q <= ROUTE;
            if (sel_q) begin
              out_a_q   <= data_q;
              valid_a_q <= 1'b1;
            end else begin
              out_b_q   <= data_q;
              valid_b_q <= 1'b1;
            end
          end
        end
        ROUTE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_a   = out_a_q;
  assign out_b   = out_b_q;
  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;
  assign ovf     = ovf_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_demux_countdown.sv
// Scoreboard bench for demux_countdown: stimulus pushes expected releases,
// a negedge monitor pops and checks them whenever a strobe appears.
module tb_demux_countdown;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         sel;
  logic         enable;
  logic         flush;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         valid_a;
  logic         valid_b;
  logic         busy;
  logic         ovf;

  demux_countdown #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .sel(sel),
    .enable(enable), .flush(flush), .out_a(out_a), .out_b(out_b),
    .valid_a(valid_a), .valid_b(valid_b), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          ch_a;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (valid_a || valid_b)) begin
      check("one_hot_strobe", 32'(valid_a & valid_b), 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check("channel_a", 32'(valid_a), 32'(e.ch_a));
        check("out_a", 32'(out_a), 32'(e.a));
        check("out_b", 32'(out_b), 32'(e.b));
        check("strobe_cycle", cyc, e.at);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) step();
  endtask

  // lat == 0 means the word is not expected to be released.
  task automatic send(input logic [W-1:0] d, input bit s, input int unsigned lat,
                      input logic [W-1:0] ea, input logic [W-1:0] eb,
                      output int unsigned cap);
    data_in  = d;
    sel      = s;
    valid_in = 1'b1;
    cap      = cyc + 1;
    if (lat != 0) sb.push_back('{ch_a: s, a: ea, b: eb, at: cap + lat});
    step();
    valid_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_a"}, 32'(out_a), 0);
    check({tag, "_out_b"}, 32'(out_b), 0);
    check({tag, "_valid_a"}, 32'(valid_a), 0);
    check({tag, "_valid_b"}, 32'(valid_b), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  int unsigned c;

  initial begin
    rst = 1'b1; data_in = '0; valid_in = 1'b0; sel = 1'b0; enable = 1'b0; flush = 1'b0;
    step(2);
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Test 1: D=3 to channel A, enable held high
    enable = 1'b1;
    send(5'd3, 1'b1, 5, 5'd3, 5'd0, c);
    check("t1_busy_after_capture", 32'(busy), 1);
    wait_cyc(c + 6);
    check("t1_busy_released", 32'(busy), 0);
    check("t1_valid_a_one_cycle", 32'(valid_a), 0);

    // Test 2: D=0 to channel B
    send(5'd0, 1'b0, 2, 5'd3, 5'd0, c);
    wait_cyc(c + 3);
    check("t2_busy_released", 32'(busy), 0);

    // Test 3: D=10 to channel A with enable alternating 1,0 from the first COUNT edge
    send(5'd10, 1'b1, 22, 5'd10, 5'd0, c);
    while (cyc < c + 23) begin
      enable = (((cyc + 1 - c) % 2) == 0);
      step();
    end
    enable = 1'b1;
    wait_cyc(c + 24);
    check("t3_busy_released", 32'(busy), 0);

    // Test 4: D=31 to channel B, flush sampled on the third edge after capture
    send(5'd31, 1'b0, 3, 5'd10, 5'd31, c);
    wait_cyc(c + 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_cyc(c + 5);
    check("t4_busy_released", 32'(busy), 0);

    // Test 5: valid_in held for 8 edges while the counter is stalled
    enable   = 1'b0;
    data_in  = 5'd2;
    sel      = 1'b1;
    valid_in = 1'b1;
    c = cyc + 1;
    sb.push_back('{ch_a: 1'b1, a: 5'd2, b: 5'd31, at: c + 10});
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) check("t5_ovf_first_request", 32'(ovf), 0);
      if (i == 1) check("t5_ovf_second_request", 32'(ovf), 1);
    end
    valid_in = 1'b0;
    enable   = 1'b1;
    wait_cyc(c + 12);
    check("t5_ovf_sticky", 32'(ovf), 1);
    check("t5_busy_released", 32'(busy), 0);
    send(5'd5, 1'b0, 7, 5'd2, 5'd5, c);
    wait_cyc(c + 9);
    check("t5_ovf_still_set", 32'(ovf), 1);

    // Test 6: async reset in the middle of counting D=20
    send(5'd20, 1'b0, 0, 5'd0, 5'd0, c);
    step(5);
    #1 rst = 1'b1;
    #2 check_all_zero("t6_async_reset");
    #1 rst = 1'b0;
    step();
    check("t6_busy_after_reset", 32'(busy), 0);
    send(5'd1, 1'b1, 3, 5'd1, 5'd0, c);
    wait_cyc(c + 30);
    check("t6_no_stray_output_b", 32'(out_b), 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
